// File: rtl/fp_sqrt_sched_pkg.sv
// Shared types and constants for the shared approximate fp32 square-root unit.
package fp_sqrt_sched_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_ONE      = 32'h3f800000;
  localparam fp32_t FP_QNAN     = 32'h7fc00000;
  localparam fp32_t FP_NEG_ZERO = 32'h80000000;

endpackage

// File: rtl/fp_sqrt_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching from ptr upward
// (wrapping), plus the pointer value to load after the grant.
module rr_arbiter #(
  parameter int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr_nxt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !gnt_any && req[j]) begin
        grant[j] = 1'b1;
        gnt_idx  = PW'(j);
        gnt_any  = 1'b1;
      end
    end
    if (!gnt_any)
      ptr_nxt = ptr;
    else if (gnt_idx == PW'(N - 1))
      ptr_nxt = '0;
    else
      ptr_nxt = gnt_idx + PW'(1);
  end

endmodule

// File: rtl/fp_sqrt_sched.sv
// Round-robin shared 2-stage approximate fp32 sqrt with tagged, backpressured
// output. Define FP_SQRT_SCHED_NEG_FLAG_EN to add the out_err negative-operand flag.
module fp_sqrt_sched
  import fp_sqrt_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int TAG_W  = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
`else
  output logic [TAG_W-1:0]      out_tag
`endif
);

  logic             w_advance;
  logic             w_en;
  logic             w_gnt_any;
  logic [TAG_W-1:0] w_gnt_idx;
  logic [TAG_W-1:0] w_ptr_nxt;
  fp32_t            w_sel_data;
  fp32_t            w_t;
  fp32_t            w_f;

  logic [TAG_W-1:0] r_rr_ptr;
  logic             r_s1_valid;
  fp32_t            r_s1_data;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  fp32_t            r_s2_data;
  logic [TAG_W-1:0] r_s2_tag;
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
  logic             r_s2_err;
`endif

  assign w_advance = !r_s2_valid || out_ready;
  assign w_en      = w_advance && !rst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .en      (w_en),
    .ptr     (r_rr_ptr),
    .grant   (req_ready),
    .ptr_nxt (w_ptr_nxt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  assign w_sel_data = req_data[32*w_gnt_idx +: 32];

  // Halve the unbiased exponent/mantissa field: arithmetic shift of (x - 1.0).
  assign w_t = r_s1_data - FP_ONE;
  assign w_f = fp32_t'($signed(w_t) >>> 1) + FP_ONE;

  // NOTE: state uses non-blocking assignments only; reset is synchronous and
  // discards in-flight operands by clearing both valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
      r_s2_err   <= 1'b0;
`endif
    end else if (w_advance) begin
      r_rr_ptr   <= w_ptr_nxt;
      r_s1_valid <= w_gnt_any;
      r_s1_data  <= w_sel_data;
      r_s1_tag   <= w_gnt_idx;
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
      if (r_s1_data[31] && (r_s1_data != FP_NEG_ZERO)) begin
        r_s2_data <= FP_QNAN;
        r_s2_err  <= 1'b1;
      end else begin
        r_s2_data <= w_f;
        r_s2_err  <= 1'b0;
      end
`else
      r_s2_data  <= w_f;
`endif
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_tag   = r_s2_tag;
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
  assign out_err   = r_s2_err;
`endif

endmodule

// File: tb/tb_fp_sqrt_sched.sv
// Directed bench for fp_sqrt_sched (NUM_REQ=4); honours FP_SQRT_SCHED_NEG_FLAG_EN.
module tb_fp_sqrt_sched;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_tag;
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
  logic         out_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fp_sqrt_sched #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
    .out_tag   (out_tag),
    .out_err   (out_err)
`else
    .out_tag   (out_tag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] val);
    req_data[32*idx +: 32] = val;
  endtask

  // Expected f() of the operands 1.0 / 4.0 / 16.0 / 1.0, computed by hand.
  logic [31:0] exp_rr [4] = '{32'h3f800000, 32'h40000000, 32'h40800000, 32'h3f800000};

  initial begin
    logic [3:0] one_hot;
    rst       = 1'b1;
    req_valid = 4'hf;
    req_data  = '0;
    out_ready = 1'b1;
    next_cycle();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_out_tag",   32'(out_tag),   32'h0);
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
    check("rst_out_err",   32'(out_err),   32'h0);
`endif

    // All four requesters valid: grants rotate 0,1,2,3,0,...
    next_cycle();
    rst = 1'b0;
    set_op(0, 32'h3f800000);
    set_op(1, 32'h40800000);
    set_op(2, 32'h41800000);
    set_op(3, 32'h3f800000);
    req_valid = 4'hf;
    #1;
    for (int k = 0; k < 8; k++) begin
      one_hot = 4'b0001 << (k % 4);
      check("rr_grant", 32'(req_ready), 32'(one_hot));
      if (k < 2) begin
        check("rr_fill_valid", 32'(out_valid), 32'h0);
      end else begin
        check("rr_out_valid", 32'(out_valid), 32'h1);
        check("rr_out_tag",   32'(out_tag),   32'((k - 2) % 4));
        check("rr_out_data",  out_data,       exp_rr[(k - 2) % 4]);
      end
      next_cycle();
    end
    req_valid = 4'h0;
    #1;
    check("rr_drain_tag2",  32'(out_tag), 32'h2);
    check("rr_drain_data2", out_data,     32'h40800000);
    next_cycle();
    check("rr_drain_tag3",  32'(out_tag), 32'h3);
    check("rr_drain_valid3", 32'(out_valid), 32'h1);
    next_cycle();
    check("rr_idle_valid", 32'(out_valid), 32'h0);

    // Single requester 0, 4.0 -> 2.0 two cycles later.
    next_cycle();
    set_op(0, 32'h40800000);
    req_valid = 4'b0001;
    #1;
    check("single_grant", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    check("single_lat1_valid", 32'(out_valid), 32'h0);
    next_cycle();
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data",  out_data,       32'h40000000);
    check("single_tag",   32'(out_tag),   32'h0);
    next_cycle();
    check("single_after_valid", 32'(out_valid), 32'h0);

    // Requesters 1 and 3, then 5 cycles of backpressure; requester 0 waits.
    next_cycle();
    set_op(1, 32'h41800000);
    set_op(3, 32'h3f800000);
    req_valid = 4'b1010;
    #1;
    check("bp_grant1", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = 4'b1000;
    #1;
    check("bp_grant3", 32'(req_ready), 32'b1000);
    next_cycle();
    set_op(0, 32'h40800000);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      check("bp_stall_valid", 32'(out_valid), 32'h1);
      check("bp_stall_tag",   32'(out_tag),   32'h1);
      check("bp_stall_data",  out_data,       32'h40800000);
      check("bp_stall_ready", 32'(req_ready), 32'h0);
      next_cycle();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b0001);
    check("bp_release_tag",   32'(out_tag),   32'h1);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    check("bp_drain_tag3",  32'(out_tag), 32'h3);
    check("bp_drain_data3", out_data,     32'h3f800000);
    next_cycle();
    check("bp_drain_tag0",  32'(out_tag), 32'h0);
    check("bp_drain_data0", out_data,     32'h40000000);
    check("bp_drain_valid0", 32'(out_valid), 32'h1);
    next_cycle();
    check("bp_idle_valid", 32'(out_valid), 32'h0);

    // Reset with two operands in flight; pointer returns to 0.
    next_cycle();
    set_op(1, 32'h3f800000);
    set_op(2, 32'h41800000);
    req_valid = 4'b0010;
    #1;
    check("mrst_grant1", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = 4'b0100;
    #1;
    check("mrst_grant2", 32'(req_ready), 32'b0100);
    next_cycle();
    rst = 1'b1;
    req_valid = 4'b0010;
    #1;
    check("mrst_in_rst_ready", 32'(req_ready), 32'h0);
    check("mrst_pre_valid",    32'(out_valid), 32'h1);
    next_cycle();
    rst = 1'b0;
    set_op(3, 32'h41800000);
    req_valid = 4'b1010;
    #1;
    check("mrst_flush_valid0", 32'(out_valid), 32'h0);
    check("mrst_lowest_grant", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    check("mrst_flush_valid1", 32'(out_valid), 32'h0);
    next_cycle();
    check("mrst_new_valid", 32'(out_valid), 32'h1);
    check("mrst_new_tag",   32'(out_tag),   32'h1);
    check("mrst_new_data",  out_data,       32'h3f800000);
    next_cycle();
    check("mrst_idle_valid", 32'(out_valid), 32'h0);

    // Negative operands from requester 2: -4.0 then -0.
    next_cycle();
    set_op(2, 32'hc0800000);
    req_valid = 4'b0100;
    #1;
    check("neg_grant_a", 32'(req_ready), 32'b0100);
    next_cycle();
    set_op(2, 32'h80000000);
    #1;
    check("neg_grant_b", 32'(req_ready), 32'b0100);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    check("neg4_valid", 32'(out_valid), 32'h1);
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
    check("neg4_data", out_data,       32'h7fc00000);
    check("neg4_err",  32'(out_err),   32'h1);
`else
    check("neg4_data", out_data,       32'h00000000);
`endif
    next_cycle();
    check("negz_valid", 32'(out_valid), 32'h1);
    check("negz_data",  out_data,       32'h5fc00000);
`ifdef FP_SQRT_SCHED_NEG_FLAG_EN
    check("negz_err",   32'(out_err),   32'h0);
`endif
    next_cycle();
    check("neg_idle_valid", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
